hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// These cover the controller states and the E-stage operand-select codes.
package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand-select for one E-stage source register.
// M beats W, and x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding,
// load-use stalls, memory-wait freezes and post-redirect decode bubbles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 2);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lw, mw, redirect;

  fwd_sel u_fwd_a (
    .rs_e_i        (rs1E),
    .rd_m_i        (rdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (rdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs_e_i        (rs2E),
    .rd_m_i        (rdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (rdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign lw = MemtoRegE && RegWriteE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign mw = MemReqM && !dmem_ready;

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    redirect = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (mw) begin
      // A freeze inside REDIRECT keeps the bubble count for when memory returns.
      {StallF, StallD, StallE, StallM} = 4'b1111;
      if (state_q != ST_REDIRECT) state_d = ST_MEM_WAIT;
    end else if (PCSrcE) begin
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      redirect = 1'b1;
      if (REDIRECT_BUBBLES == 0) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end else begin
        state_d = ST_REDIRECT;
        cnt_d   = 3'(REDIRECT_BUBBLES);
      end
    end else if (state_q == ST_REDIRECT) begin
      FlushD = 1'b1;
      if (cnt_q <= 3'd1) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else begin
      state_d = ST_RUN;
      if (lw) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    wcnt_d = '0;
    if (mw) wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
    err_d = err_q || (mw && (wcnt_d >= WCNT_W'(MEM_TIMEOUT)));
    stall_cnt_d = stall_cnt_q;
    if (StallF && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 3'd0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err_timeout  = err_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with REDIRECT_BUBBLES=1 and MEM_TIMEOUT=8.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MemReqM, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, err_timeout;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REDIRECT_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .err_timeout(err_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcE = 0; MemReqM = 0; dmem_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #12;
    checks++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin errors++; $display("FAIL rst_stalls got %b exp 0000", {StallF, StallD, StallE, StallM}); end
    checks++; if ({FlushD, FlushE} !== 2'b00) begin errors++; $display("FAIL rst_flushes got %b exp 00", {FlushD, FlushE}); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b exp 0000", {ForwardAE, ForwardBE}); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_timeout); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", stall_cycles, flush_events); end
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_forward();
    clear_inputs();
    rs1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1;
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_beats_w got %b exp 10", ForwardAE); end
    RegWriteM = 0; #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got %b exp 01", ForwardAE); end
    rdM = 0; rdW = 0; RegWriteM = 1; rs1E = 0; #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", ForwardAE); end
    rs2E = 7; rdW = 7; rdM = 5; #1;
    checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_w got %b exp 01", ForwardBE); end
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_a_idle got %b exp 00", ForwardAE); end
    clear_inputs();
    $display("test_forward done");
  endtask

  task automatic test_load_use();
    tick();
    MemtoRegE = 1; RegWriteE = 1; rdE = 3; rs2D = 3; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b111) begin errors++; $display("FAIL lu_stall got %b exp 111", {StallF, StallD, FlushE}); end
    checks++; if ({StallE, StallM, FlushD} !== 3'b000) begin errors++; $display("FAIL lu_others got %b exp 000", {StallE, StallM, FlushD}); end
    tick();
    clear_inputs(); #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL lu_release got %b exp 000", {StallF, StallD, FlushE}); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_stall_cycles got %0d exp 1", stall_cycles); end
    MemtoRegE = 1; RegWriteE = 1; rdE = 0; rs1D = 0; #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL lu_x0 got %b exp 0", StallF); end
    clear_inputs();
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    tick();
    PCSrcE = 1; #1;
    checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin errors++; $display("FAIL br_c0 got %b exp 1100", {FlushD, FlushE, StallF, StallD}); end
    tick();
    PCSrcE = 0; MemtoRegE = 1; RegWriteE = 1; rdE = 4; rs1D = 4; #1;
    checks++; if ({FlushD, FlushE, StallF} !== 3'b100) begin errors++; $display("FAIL br_c1 got %b exp 100", {FlushD, FlushE, StallF}); end
    tick();
    clear_inputs(); #1;
    checks++; if ({FlushD, FlushE} !== 2'b00) begin errors++; $display("FAIL br_c2 got %b exp 00", {FlushD, FlushE}); end
    checks++; if (flush_events !== 32'd1) begin errors++; $display("FAIL br_flush_events got %0d exp 1", flush_events); end
    $display("test_branch done");
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      tick();
      MemReqM = 1; dmem_ready = 0; #1;
      checks++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin errors++; $display("FAIL mw_cycle%0d got %b exp 111100", i, {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
    end
    tick();
    dmem_ready = 1; #1;
    checks++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin errors++; $display("FAIL mw_ready got %b exp 0000", {StallF, StallD, StallE, StallM}); end
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL mw_stall_cycles got %0d exp 5", stall_cycles); end
    tick();
    clear_inputs();
    // branch held across a two-cycle freeze
    for (int i = 0; i < 2; i++) begin
      tick();
      MemReqM = 1; dmem_ready = 0; PCSrcE = 1; #1;
      checks++; if ({StallF, FlushD, FlushE} !== 3'b100) begin errors++; $display("FAIL mwbr_freeze%0d got %b exp 100", i, {StallF, FlushD, FlushE}); end
    end
    tick();
    dmem_ready = 1; #1;
    checks++; if ({StallF, FlushD, FlushE} !== 3'b011) begin errors++; $display("FAIL mwbr_ready got %b exp 011", {StallF, FlushD, FlushE}); end
    tick();
    clear_inputs(); #1;
    checks++; if ({FlushD, FlushE} !== 2'b10) begin errors++; $display("FAIL mwbr_bubble got %b exp 10", {FlushD, FlushE}); end
    checks++; if (flush_events !== 32'd2) begin errors++; $display("FAIL mwbr_flush_events got %0d exp 2", flush_events); end
    tick();
    #1;
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL mwbr_done got %b exp 0", FlushD); end
    // freeze arriving during the redirect bubble
    PCSrcE = 1; tick();
    PCSrcE = 0; MemReqM = 1; dmem_ready = 0; #1;
    checks++; if ({StallF, StallM, FlushD} !== 3'b110) begin errors++; $display("FAIL rdmw_freeze got %b exp 110", {StallF, StallM, FlushD}); end
    tick();
    dmem_ready = 1; #1;
    checks++; if ({StallF, FlushD} !== 2'b01) begin errors++; $display("FAIL rdmw_resume got %b exp 01", {StallF, FlushD}); end
    tick();
    clear_inputs(); #1;
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL rdmw_done got %b exp 0", FlushD); end
    checks++; if (stall_cycles !== 32'd8 || flush_events !== 32'd3) begin errors++; $display("FAIL rdmw_counters got %0d/%0d exp 8/3", stall_cycles, flush_events); end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    MemReqM = 1; dmem_ready = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (err_timeout !== (k >= 8)) begin errors++; $display("FAIL to_after%0d got %b exp %b", k, err_timeout, (k >= 8)); end
    end
    dmem_ready = 1;
    tick();
    MemReqM = 0; #1;
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
    checks++; if (stall_cycles !== 32'd18) begin errors++; $display("FAIL to_stall_cycles got %0d exp 18", stall_cycles); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_abort();
    MemReqM = 1; dmem_ready = 0;
    tick(); tick(); tick();
    #2 rst = 1'b1; MemReqM = 0; dmem_ready = 1;
    #1;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL ra_err got %b exp 0", err_timeout); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin errors++; $display("FAIL ra_counters got %0d/%0d exp 0/0", stall_cycles, flush_events); end
    checks++; if ({StallF, StallM} !== 2'b00) begin errors++; $display("FAIL ra_stalls got %b exp 00", {StallF, StallM}); end
    tick();
    rst = 1'b0;
    PCSrcE = 1;
    tick();
    PCSrcE = 0; #1;
    checks++; if (FlushD !== 1'b1) begin errors++; $display("FAIL ra_redirect got %b exp 1", FlushD); end
    #1 rst = 1'b1;
    #1;
    checks++; if (FlushD !== 1'b0) begin errors++; $display("FAIL ra_redirect_abort got %b exp 0", FlushD); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({FlushD, FlushE, StallF} !== 3'b000 || flush_events !== 32'd0) begin errors++; $display("FAIL ra_idle got %b/%0d exp 000/0", {FlushD, FlushE, StallF}, flush_events); end
    $display("test_reset_abort done");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
